// File: rtl/hamming_cw_deserializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : hamming_cw_deserializer_pkg
//  Brief   : Shared Hamming (38,32) widths and receive FSM state type.
//  Revision: 1.0 - initial release
// ============================================================================
package hamming_cw_deserializer_pkg;

  localparam int HAM_DATA_W = 32;
  localparam int HAM_PAR_W  = 6;
  localparam int HAM_CW_W   = HAM_DATA_W + HAM_PAR_W;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/hamming_cw_deserializer_if.sv
`default_nettype none
// ============================================================================
//  Module  : hamming_cw_deserializer_if
//  Brief   : Serial input and valid/ready codeword output bundle.
//  Revision: 1.0 - initial release
// ============================================================================
interface hamming_cw_deserializer_if
  import hamming_cw_deserializer_pkg::*;
#(
  parameter int CW_W = HAM_CW_W
) ();

  logic            ser_in;
  logic            ser_valid;
  logic            ser_sof;
  logic [CW_W-1:0] cw_out;
  logic            cw_valid;
  logic            cw_ready;

  // Source of serial bits and consumer of codewords
  modport master (
    output ser_in, ser_valid, ser_sof, cw_ready,
    input  cw_out, cw_valid
  );

  // Deserializer side
  modport slave (
    input  ser_in, ser_valid, ser_sof, cw_ready,
    output cw_out, cw_valid
  );

endinterface
`default_nettype wire

// File: rtl/hamming_cw_deserializer_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module  : sat_counter
//  Brief   : Up-counter that sticks at all-ones instead of wrapping.
//  Revision: 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 16
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         i_inc,
  output logic [W-1:0]      o_count
);

  logic [W-1:0] r_count;

  // Count increment requests until saturation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/hamming_cw_deserializer.sv
`default_nettype none
// ============================================================================
//  Module  : hamming_cw_deserializer
//  Brief   : Frames serial Hamming codewords on sof, assembles CW_W bits and
//            hands them off through a one-entry valid/ready buffer. Frames
//            completing into a full buffer are dropped and counted.
//  Revision: 1.0 - initial release
// ============================================================================
module hamming_cw_deserializer
  import hamming_cw_deserializer_pkg::*;
#(
  parameter int CW_W      = HAM_CW_W,
  parameter int CNT_W     = 16,
  parameter bit MSB_FIRST = 1'b0
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  hamming_cw_deserializer_if.slave   bus,
  output logic                       frame_err,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic [CNT_W-1:0]           frame_err_cnt
);

  localparam int              C_BC_W = $clog2(CW_W);
  localparam logic [C_BC_W-1:0] C_LAST = C_BC_W'(CW_W - 1);
  localparam logic [C_BC_W-1:0] C_ONE  = C_BC_W'(1);

  state_t            r_state;
  logic [C_BC_W-1:0] r_bit_cnt;
  logic [CW_W-1:0]   r_shift;
  logic [CW_W-1:0]   r_cw_out;
  logic              r_cw_valid;
  logic              r_frame_err;

  state_t            w_state_nxt;
  logic [C_BC_W-1:0] w_cnt_nxt;
  logic [CW_W-1:0]   w_shift_nxt;
  logic [CW_W-1:0]   w_word;
  logic              w_abort;
  logic              w_complete;
  logic              w_buf_free;
  logic              w_drop;
  logic [C_BC_W-1:0] w_pos;
  logic [C_BC_W-1:0] w_pos0;

  // Map the running bit count onto a codeword bit position
  if (MSB_FIRST) begin : g_msb_first
    assign w_pos  = C_LAST - r_bit_cnt;
    assign w_pos0 = C_LAST;
  end else begin : g_lsb_first
    assign w_pos  = r_bit_cnt;
    assign w_pos0 = '0;
  end

  // Next-state, assembly and framing decisions for the current qualified bit
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_word      = r_shift;
    w_abort     = 1'b0;
    w_complete  = 1'b0;
    if (bus.ser_valid) begin
      if (bus.ser_sof) begin
        // sof always restarts, even on the position that would complete a frame
        w_abort             = (r_state == ST_RECV);
        w_shift_nxt         = '0;
        w_shift_nxt[w_pos0] = bus.ser_in;
        w_cnt_nxt           = C_ONE;
        w_state_nxt         = ST_RECV;
      end else if (r_state == ST_RECV) begin
        w_word[w_pos] = bus.ser_in;
        if (r_bit_cnt == C_LAST) begin
          w_complete  = 1'b1;
          w_shift_nxt = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_shift_nxt = w_word;
          w_cnt_nxt   = r_bit_cnt + C_ONE;
        end
      end
    end
  end

  // Buffer can take a word if empty or being emptied this very cycle
  assign w_buf_free = !r_cw_valid || bus.cw_ready;
  assign w_drop     = w_complete && !w_buf_free;

  // FSM state, bit counter and assembly register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_cnt_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  // One-entry output buffer and abort pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cw_out    <= '0;
      r_cw_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_abort;
      if (w_complete && w_buf_free) begin
        r_cw_out   <= w_word;
        r_cw_valid <= 1'b1;
      end else if (bus.cw_ready) begin
        r_cw_valid <= 1'b0;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_drop),
    .o_count (drop_cnt)
  );

  sat_counter #(.W(CNT_W)) u_frame_err_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (r_frame_err),
    .o_count (frame_err_cnt)
  );

  assign bus.cw_out   = r_cw_out;
  assign bus.cw_valid = r_cw_valid;
  assign frame_err    = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_hamming_cw_deserializer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_hamming_cw_deserializer
//  Brief   : Directed self-checking bench with an expected-codeword queue.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_hamming_cw_deserializer;
  import hamming_cw_deserializer_pkg::*;

  localparam int CW_W  = HAM_CW_W;
  localparam int CNT_W = 2;

  localparam logic [CW_W-1:0] C_W1 = 38'h2A_5A5A_5A5A;
  localparam logic [CW_W-1:0] C_W3 = 38'h3F_FFFF_FFFF;
  localparam logic [CW_W-1:0] C_WA = 38'h12_3456_789A;
  localparam logic [CW_W-1:0] C_WB = 38'h0D_CAFE_F00D;
  localparam logic [CW_W-1:0] C_WC = 38'h25_DEAD_BEEF;
  localparam logic [CW_W-1:0] C_WE = 38'h01_8000_0001;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             frame_err;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] frame_err_cnt;

  int checks   = 0;
  int failures = 0;
  int fe_pulses;
  logic valid_before_last;
  logic [CW_W-1:0] sb_q[$];

  hamming_cw_deserializer_if #(.CW_W(CW_W)) bus ();

  hamming_cw_deserializer #(
    .CW_W      (CW_W),
    .CNT_W     (CNT_W),
    .MSB_FIRST (1'b0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .frame_err     (frame_err),
    .drop_cnt      (drop_cnt),
    .frame_err_cnt (frame_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pop(input string tag);
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s: observed=%0h expected=<empty scoreboard>", tag, bus.cw_out);
    end else begin
      chk(tag, 64'(bus.cw_out), 64'(sb_q.pop_front()));
    end
  endtask

  // Sends nbits of w, LSB first, sof on the first; optional idle gap per bit
  task automatic send_frame(input logic [CW_W-1:0] w, input int nbits,
                            input bit gap, input bit ready_last);
    for (int i = 0; i < nbits; i++) begin
      bus.ser_valid = 1'b1;
      bus.ser_in    = w[i];
      bus.ser_sof   = (i == 0);
      if (i == nbits - 1) begin
        valid_before_last = bus.cw_valid;
        if (ready_last) bus.cw_ready = 1'b1;
      end
      tick();
      if (frame_err) fe_pulses++;
      bus.ser_valid = 1'b0;
      bus.ser_sof   = 1'b0;
      if (gap && (i != nbits - 1)) begin
        tick();
        if (frame_err) fe_pulses++;
      end
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.ser_in    = 1'b0;
    bus.ser_valid = 1'b0;
    bus.ser_sof   = 1'b0;
    bus.cw_ready  = 1'b1;
    fe_pulses     = 0;
    repeat (3) tick();
    chk("rst_cw_valid", 64'(bus.cw_valid), 64'd0);
    chk("rst_cw_out", 64'(bus.cw_out), 64'd0);
    chk("rst_counters", {drop_cnt, frame_err_cnt, frame_err}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Test 1: back-to-back frame, consumer ready
    sb_q.push_back(C_W1);
    send_frame(C_W1, CW_W, 1'b0, 1'b0);
    chk("t1_valid_before_last", 64'(valid_before_last), 64'd0);
    chk("t1_valid", 64'(bus.cw_valid), 64'd1);
    chk_pop("t1_cw_out");
    tick();
    chk("t1_valid_one_cycle", 64'(bus.cw_valid), 64'd0);
    chk("t1_counters", {drop_cnt, frame_err_cnt}, 64'd0);
    chk("t1_no_frame_err", 64'(fe_pulses), 64'd0);

    // Test 2: same frame with idle gaps between bits
    sb_q.push_back(C_W1);
    send_frame(C_W1, CW_W, 1'b1, 1'b0);
    chk("t2_valid", 64'(bus.cw_valid), 64'd1);
    chk_pop("t2_cw_out");
    chk("t2_no_frame_err", 64'(fe_pulses), 64'd0);
    tick();

    // Test 3: aborted frame followed by a full frame
    send_frame(C_WA, 10, 1'b0, 1'b0);
    sb_q.push_back(C_W3);
    send_frame(C_W3, CW_W, 1'b0, 1'b0);
    chk("t3_frame_err_pulses", 64'(fe_pulses), 64'd1);
    chk("t3_frame_err_cnt", 64'(frame_err_cnt), 64'd1);
    chk("t3_valid", 64'(bus.cw_valid), 64'd1);
    chk_pop("t3_cw_out");
    tick();
    chk("t3_frame_err_low", 64'(frame_err), 64'd0);

    // Test 4: consumer stalled, second frame dropped
    bus.cw_ready = 1'b0;
    sb_q.push_back(C_WA);
    send_frame(C_WA, CW_W, 1'b0, 1'b0);
    send_frame(C_WB, CW_W, 1'b0, 1'b0);
    chk("t4_drop_cnt", 64'(drop_cnt), 64'd1);
    chk("t4_valid_held", 64'(bus.cw_valid), 64'd1);
    bus.cw_ready = 1'b1;
    chk_pop("t4_cw_out_held");
    tick();
    chk("t4_valid_cleared", 64'(bus.cw_valid), 64'd0);

    // Test 5: handshake in the completion cycle of the next frame
    bus.cw_ready = 1'b0;
    sb_q.push_back(C_WA);
    send_frame(C_WA, CW_W, 1'b0, 1'b0);
    chk_pop("t5_first_word");
    sb_q.push_back(C_WB);
    send_frame(C_WB, CW_W, 1'b0, 1'b1);
    chk("t5_valid_stays", 64'(bus.cw_valid), 64'd1);
    chk_pop("t5_second_word");
    chk("t5_drop_unchanged", 64'(drop_cnt), 64'd1);
    tick();
    chk("t5_valid_cleared", 64'(bus.cw_valid), 64'd0);

    // Test 6: asynchronous reset with a buffered word and a partial frame
    bus.cw_ready = 1'b0;
    send_frame(C_WC, CW_W, 1'b0, 1'b0);
    chk("t6_buffered", 64'(bus.cw_valid), 64'd1);
    send_frame(C_WA, 21, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 64'(bus.cw_valid), 64'd0);
    chk("t6_async_cw_out", 64'(bus.cw_out), 64'd0);
    chk("t6_async_counters", {drop_cnt, frame_err_cnt, frame_err}, 64'd0);
    sb_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    bus.cw_ready = 1'b1;
    for (int i = 0; i < CW_W; i++) begin
      bus.ser_valid = 1'b1;
      bus.ser_in    = 1'b1;
      bus.ser_sof   = 1'b0;
      tick();
      if (i == 4) chk("t6_five_bits_ignored", 64'(bus.cw_valid), 64'd0);
    end
    bus.ser_valid = 1'b0;
    tick();
    chk("t6_nonsof_ignored", 64'(bus.cw_valid), 64'd0);
    chk("t6_no_drop_after_rst", 64'(drop_cnt), 64'd0);

    // Saturating drop counter with CNT_W=2
    bus.cw_ready = 1'b0;
    sb_q.push_back(C_WE);
    send_frame(C_WE, CW_W, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      send_frame(C_WB, CW_W, 1'b0, 1'b0);
      if (k == 1) chk("t6_drop_cnt_2", 64'(drop_cnt), 64'd2);
    end
    chk("t6_drop_cnt_sat", 64'(drop_cnt), 64'd3);
    chk_pop("t6_cw_out_kept");
    bus.cw_ready = 1'b1;
    tick();
    chk("t6_valid_cleared", 64'(bus.cw_valid), 64'd0);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
